// File: rtl/signal_bounce_gen_pkg.sv
// Shared definitions for the bounce generator and the filter chain around it:
// FSM state encoding, LFSR tap mask, default seed and the LFSR step function.
package signal_bounce_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BOUNCE = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/signal_bounce_gen_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; steps every cycle out of reset.
module lfsr16
  import signal_bounce_gen_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST_n,
  output logic [15:0] q
);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) q <= SEED;
    else        q <= lfsr_next(q);
  end

endmodule

// File: rtl/signal_bounce_gen.sv
// Programmable contact-bounce source: drives oSignal to a target level through
// pseudo-random glitches, holds it for a settle period, and emits edge pulses.
module signal_bounce_gen
  import signal_bounce_gen_pkg::*;
#(
  parameter int          BOUNCE_MAX = 8,
  parameter int          GLITCH_W   = 4,
  parameter int          SETTLE     = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        iStart,
  input  logic        iLevel,
  input  logic [3:0]  iBounces,
  output logic        oSignal,
  output logic        H2L_Sig,
  output logic        L2H_Sig,
  output logic        oBusy,
  output logic        oDone,
  output state_t      dbg_state,
  output logic [15:0] dbg_lfsr
);

  localparam int         SW    = $clog2(SETTLE + 1);
  localparam logic [3:0] N_MAX = 4'(BOUNCE_MAX);

  state_t               state;
  logic                 tgt;
  logic [3:0]           n;
  logic [GLITCH_W-1:0]  hold_cnt;
  logic [SW-1:0]        settle_cnt;
  logic                 sig_d;
  logic [15:0]          lfsr_q;
  logic [GLITCH_W-1:0]  glitch_w;
  logic [3:0]           n_req;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .CLK   (CLK),
    .RST_n (RST_n),
    .q     (lfsr_q)
  );

  // Forcing bit 0 keeps every glitch at least one cycle wide
  assign glitch_w = lfsr_q[GLITCH_W-1:0] | GLITCH_W'(1);
  assign n_req    = (iBounces > N_MAX) ? N_MAX : iBounces;

  assign H2L_Sig   = sig_d & ~oSignal;
  assign L2H_Sig   = ~sig_d & oSignal;
  assign dbg_state = state;
  assign dbg_lfsr  = lfsr_q;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state      <= ST_IDLE;
      oSignal    <= 1'b0;
      sig_d      <= 1'b0;
      oBusy      <= 1'b0;
      oDone      <= 1'b0;
      tgt        <= 1'b0;
      n          <= '0;
      hold_cnt   <= '0;
      settle_cnt <= '0;
    end else begin
      sig_d <= oSignal;
      oDone <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (iStart) begin
            tgt        <= iLevel;
            oBusy      <= 1'b1;
            settle_cnt <= '0;
            if (n_req == 4'd0) begin
              oSignal <= iLevel;
              n       <= '0;
              state   <= ST_SETTLE;
            end else begin
              // First toggle happens on the accepting edge itself
              oSignal  <= ~oSignal;
              n        <= n_req - 4'd1;
              hold_cnt <= glitch_w;
              state    <= ST_BOUNCE;
            end
          end
        end
        ST_BOUNCE: begin
          if (hold_cnt == GLITCH_W'(1)) begin
            if (n == 4'd0) begin
              oSignal <= tgt;
              state   <= ST_SETTLE;
            end else begin
              oSignal  <= ~oSignal;
              n        <= n - 4'd1;
              hold_cnt <= glitch_w;
            end
          end else begin
            hold_cnt <= hold_cnt - GLITCH_W'(1);
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SW'(SETTLE - 1)) begin
            oDone <= 1'b1;
            state <= ST_DONE;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        ST_DONE: begin
          oBusy <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_signal_bounce_gen.sv
// Bench for signal_bounce_gen: per-request expected waveform queue built from
// an independent LFSR model, compared cycle by cycle on the falling edge.
module tb_signal_bounce_gen;
  import signal_bounce_gen_pkg::*;

  localparam int          SETTLE_C = 16;
  localparam int          BMAX     = 8;
  localparam logic [15:0] SEED     = 16'hACE1;

  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic        iStart = 1'b0;
  logic        iLevel = 1'b0;
  logic [3:0]  iBounces = 4'd0;
  logic        oSignal, H2L_Sig, L2H_Sig, oBusy, oDone;
  state_t      dbg_state;
  logic [15:0] dbg_lfsr;

  int vectors = 0;
  int miscompares = 0;

  // Entry layout: {sig, h2l, l2h, busy, done}
  logic [4:0]  exp_q[$];
  logic [15:0] m_lfsr = 16'hACE1;
  logic        cur_sig = 1'b0;
  int          exp_l2h, exp_h2l;

  signal_bounce_gen #(
    .BOUNCE_MAX (BMAX),
    .GLITCH_W   (4),
    .SETTLE     (SETTLE_C),
    .LFSR_SEED  (SEED)
  ) dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .iStart    (iStart),
    .iLevel    (iLevel),
    .iBounces  (iBounces),
    .oSignal   (oSignal),
    .H2L_Sig   (H2L_Sig),
    .L2H_Sig   (L2H_Sig),
    .oBusy     (oBusy),
    .oDone     (oDone),
    .dbg_state (dbg_state),
    .dbg_lfsr  (dbg_lfsr)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] model_next(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

  always @(posedge CLK or negedge RST_n) begin
    if (!RST_n) m_lfsr = SEED;
    else        m_lfsr = model_next(m_lfsr);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push_exp(input logic sig, input logic prev, input logic busy, input logic done);
    exp_q.push_back({sig, prev & ~sig, ~prev & sig, busy, done});
    if (~prev & sig) exp_l2h++;
    if (prev & ~sig) exp_h2l++;
  endtask

  // Expected waveform for cycles 1.. after the request cycle 0
  task automatic build_expected(input logic lvl, input logic [3:0] nb);
    logic [15:0] l;
    logic        cur, prev;
    int          n, h;
    l = m_lfsr;
    cur = cur_sig;
    prev = cur_sig;
    n = (int'(nb) > BMAX) ? BMAX : int'(nb);
    exp_l2h = 0;
    exp_h2l = 0;
    for (int i = 0; i < n; i++) begin
      cur = ~cur;
      h = int'(l[3:0] | 4'd1);
      for (int c = 0; c < h; c++) begin
        push_exp(cur, prev, 1'b1, 1'b0);
        prev = cur;
        l = model_next(l);
      end
    end
    for (int c = 0; c < SETTLE_C; c++) begin
      push_exp(lvl, prev, 1'b1, 1'b0);
      prev = lvl;
    end
    push_exp(lvl, lvl, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) push_exp(lvl, lvl, 1'b0, 1'b0);
    cur_sig = lvl;
  endtask

  task automatic check_cycle(input string name, input int cyc);
    logic [4:0] exp_v, obs_v;
    exp_v = exp_q.pop_front();
    obs_v = {oSignal, H2L_Sig, L2H_Sig, oBusy, oDone};
    vectors++;
    if (obs_v !== exp_v) begin
      miscompares++;
      $display("FAIL %s cycle %0d outputs {sig,h2l,l2h,busy,done}: got %b expected %b",
               name, cyc, obs_v, exp_v);
    end
    vectors++;
    if (dbg_lfsr !== m_lfsr) begin
      miscompares++;
      $display("FAIL %s cycle %0d lfsr: got %h expected %h", name, cyc, dbg_lfsr, m_lfsr);
    end
  endtask

  // inj_cycle: 0 = no extra pulse, -1 = pulse in the DONE cycle, else that cycle
  task automatic run_request(input string name, input logic lvl, input logic [3:0] nb,
                             input int inj_cycle, input logic inj_lvl);
    int cyc, inj, l2h_seen, h2l_seen;
    @(negedge CLK);
    build_expected(lvl, nb);
    inj = (inj_cycle < 0) ? exp_q.size() - 3 : inj_cycle;
    iStart = 1'b1;
    iLevel = lvl;
    iBounces = nb;
    cyc = 0;
    l2h_seen = 0;
    h2l_seen = 0;
    while (exp_q.size() > 0) begin
      @(negedge CLK);
      cyc++;
      iStart = (cyc == inj);
      if (cyc == inj) begin
        iLevel = inj_lvl;
        iBounces = 4'd2;
      end
      l2h_seen += int'(L2H_Sig);
      h2l_seen += int'(H2L_Sig);
      check_cycle(name, cyc);
    end
    iStart = 1'b0;
    vectors++;
    if (l2h_seen != exp_l2h || h2l_seen != exp_h2l) begin
      miscompares++;
      $display("FAIL %s edge counts: got l2h=%0d h2l=%0d expected l2h=%0d h2l=%0d",
               name, l2h_seen, h2l_seen, exp_l2h, exp_h2l);
    end
  endtask

  task automatic apply_reset();
    iStart = 1'b0;
    RST_n = 1'b0;
    repeat (3) @(negedge CLK);
    RST_n = 1'b1;
    cur_sig = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    vectors++;
    if ({oSignal, H2L_Sig, L2H_Sig, oBusy, oDone} !== 5'b0 || dbg_state !== ST_IDLE) begin
      miscompares++;
      $display("FAIL %s: got {sig,h2l,l2h,busy,done}=%b state=%0d expected 00000 state=0",
               name, {oSignal, H2L_Sig, L2H_Sig, oBusy, oDone}, dbg_state);
    end
  endtask

  task automatic test_reset();
    RST_n = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset_hold");
    RST_n = 1'b1;
    #1;
    vectors++;
    if (dbg_lfsr !== 16'hACE1) begin
      miscompares++;
      $display("FAIL reset_seed: lfsr got %h expected ace1", dbg_lfsr);
    end
    cur_sig = 1'b0;
  endtask

  task automatic test_mid_reset();
    @(negedge CLK);
    build_expected(1'b1, 4'd15);
    iStart = 1'b1;
    iLevel = 1'b1;
    iBounces = 4'd15;
    for (int c = 1; c <= 6; c++) begin
      @(negedge CLK);
      iStart = 1'b0;
      check_cycle("mid_reset_pre", c);
    end
    #2;
    RST_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset_abort");
    exp_q.delete();
    cur_sig = 1'b0;
    @(negedge CLK);
    check_reset_outputs("mid_reset_held");
    RST_n = 1'b1;
    run_request("after_reset", 1'b1, 4'd0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    run_request("zero_bounce", 1'b1, 4'd0, 0, 1'b0);
    apply_reset();
    run_request("five_bounce", 1'b1, 4'd5, 0, 1'b0);
    apply_reset();
    run_request("clamp", 1'b1, 4'd15, 0, 1'b0);
    run_request("ignore_busy", 1'b1, 4'd6, 2, 1'b0);
    run_request("ignore_done", 1'b0, 4'd2, -1, 1'b1);
    run_request("back_to_back_a", 1'b0, 4'd3, 0, 1'b0);
    run_request("back_to_back_b", 1'b1, 4'd1, 0, 1'b0);
    run_request("same_level", 1'b1, 4'd0, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_request("random", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 0, 1'b0);
    end
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
